// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch unit: sequencer states, the decoder's
// unmapped-target marker and the jump opcodes owned by the control decoder.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [15:0] kNULL_TARGET = 16'h0000;

  // Jump opcodes decoded upstream; listed here so both ends share one source.
  localparam logic [3:0] kJ    = 4'h8;
  localparam logic [3:0] kBRE  = 4'h9;
  localparam logic [3:0] kBRGT = 4'hA;

endpackage

// File: rtl/inst_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Program counter / fetch sequencer: consumes the decoder's jump_en/Target
// interface and steps the ROM address through IDLE, RUN, DONE and FAULT.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                 PC_W   = 16,
  parameter logic [PC_W-1:0]    PC_MAX = 16'h03FF,
  parameter int                 JCNT_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Halt,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic              Fault,
  output logic [15:0]       InstCount,
  output logic [JCNT_W-1:0] JumpCount
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic            targetBad;
  logic            instInc;
  logic            jumpInc;

  // Target 0 is what the decoder emits for an unmapped entry, never a real jump.
  assign targetBad = (Target == PC_W'(kNULL_TARGET)) || (Target > PC_MAX);

  // Every RUN cycle retires exactly one instruction, whatever it turns out to be.
  assign instInc = !Start && (state_q == RUN);
  assign jumpInc = instInc && !Halt && jump_en && !targetBad;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else if (Start) begin
      pc_q    <= StartAddr;
      state_q <= (StartAddr > PC_MAX) ? FAULT : RUN;
    end else if (state_q == RUN) begin
      if (Halt) begin
        state_q <= DONE;
      end else if (jump_en) begin
        if (targetBad) begin
          state_q <= FAULT;
        end else begin
          pc_q <= Target;
        end
      end else if (pc_q == PC_MAX) begin
        state_q <= DONE;
      end else begin
        pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  sat_counter #(.W(16)) uInstCount (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (Start),
    .inc   (instInc),
    .count (InstCount)
  );

  sat_counter #(.W(JCNT_W)) uJumpCount (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (Start),
    .inc   (jumpInc),
    .count (JumpCount)
  );

  assign ProgCtr = pc_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign Fault   = (state_q == FAULT);

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter / fetch unit: the consumer end of the control decoder's `jump_en` / `Target` interface.
- Holds the 16-bit PC that addresses the instruction ROM and sequences it through start, run, halt and fault.
- On a taken jump it loads `Target` as an absolute address; otherwise it increments.
- Keeps retired-instruction and taken-jump counters for the test harness.

Parameters:
- PC_W, 16: width of PC, `Target` and `StartAddr`.
- PC_MAX, 16'h03FF: last valid instruction address (ROM depth minus 1).
- JCNT_W, 8: width of the taken-jump counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; begin execution at StartAddr.
- StartAddr  in  PC_W  entry address sampled when Start=1.
- Halt  in  1  decoded halt instruction at the current PC.
- jump_en  in  1  taken-jump request from the control decoder.
- Target  in  PC_W  absolute jump address from the control decoder.
- ProgCtr  out  PC_W  current PC, drives the instruction ROM address.
- Running  out  1  state==RUN.
- Done  out  1  state==DONE (level).
- Fault  out  1  state==FAULT (level).
- InstCount  out  16  instructions retired since last Start.
- JumpCount  out  JCNT_W  taken jumps since last Start.

Behaviour:
- Reset (async, any state, mid-run included):
  - state=IDLE, ProgCtr=0, InstCount=0, JumpCount=0.
  - Running=Done=Fault=0.
- States: IDLE, RUN, DONE, FAULT. All outputs are registered or decoded from state; nothing is combinational from inputs.
- Priority each cycle: Start > Halt > jump_en > increment.
- Start=1, any state, including RUN (restart):
  - next state RUN, ProgCtr<=StartAddr, both counters cleared.
  - If StartAddr>PC_MAX: next state FAULT, ProgCtr<=StartAddr.
- IDLE/DONE/FAULT without Start: hold all registers. Halt and jump_en are ignored.
- RUN, Halt=1: the halt instruction retires; next state DONE.
  - ProgCtr holds.
  - InstCount+1.
- RUN, jump_en=1:
  - Target==0: Target 0 is the decoder's unmapped-entry value and is never a legal destination. Next state FAULT, ProgCtr holds, InstCount+1, JumpCount unchanged.
  - Target>PC_MAX: same as Target==0 (FAULT).
  - Otherwise: ProgCtr<=Target, InstCount+1, JumpCount+1.
- RUN, no jump, no halt:
  - ProgCtr==PC_MAX: running off the end of the ROM is normal termination. Next state DONE, ProgCtr holds, InstCount+1.
  - Else ProgCtr<=ProgCtr+1, InstCount+1.
- Latency: a jump or increment is visible on ProgCtr on the cycle after the request. The decoder sees the new instruction the same cycle ProgCtr updates.
- Counters saturate: InstCount at 16'hFFFF, JumpCount at all-ones. No wrap.
- PC never wraps; it is bounded by PC_MAX as above.
- Start and Halt in the same cycle: Start wins, no DONE.

Decomposition:
- Shared package (definitions): typedef enum logic[1:0] fetch_state_t {IDLE, RUN, DONE, FAULT}; constant kNULL_TARGET=16'h0000.
- The kJ/kBRE/kBRGT opcodes stay in definitions; this block does not decode opcodes.
- Sub-module sat_counter (parameter W; inputs clr, inc; output count). Instantiated twice, for InstCount and JumpCount.

Test Plan:
- Reset mid-RUN at PC=16'h0042 -> same cycle: ProgCtr=0, state IDLE, counters 0, Running=0.
- Start with StartAddr=16'h0003, run 5 cycles with no jump -> ProgCtr 3,4,5,6,7,8; InstCount=5; Running=1.
- At PC=16'h0005, jump_en=1, Target=16'h01FF -> next cycle ProgCtr=16'h01FF; JumpCount=1.
- At PC=16'h0010, jump_en=1, Target=0 -> next cycle Fault=1, ProgCtr=16'h0010. Then Start with StartAddr=3 -> RUN, ProgCtr=3, Fault=0, counters 0.
- Start with StartAddr=PC_MAX-1, no jumps -> ProgCtr 16'h03FE, 16'h03FF, then Done=1 with ProgCtr held at 16'h03FF; InstCount=2.
- Halt and jump_en together at PC=16'h0020 -> DONE, ProgCtr=16'h0020, JumpCount unchanged. Start and Halt together -> RUN at StartAddr.
